// File: rtl/amp_scaler_pipe_if.sv
// Sample/gain bus for amp_scaler_pipe; clip_clr/clip_cnt exist only when
// AMP_SCALER_CLIP_CNT_EN is defined.
interface amp_scaler_pipe_if #(
  parameter int DATA_W = 14,
  parameter int GAIN_W = 12
);
  logic [GAIN_W-1:0] gain_mv;
  logic              gain_load;
  logic              din_valid;
  logic [DATA_W-1:0] din;
  logic              dout_valid;
  logic [DATA_W-1:0] dout;
  logic              clip;
  logic              busy;
  logic              pending;
`ifdef AMP_SCALER_CLIP_CNT_EN
  logic              clip_clr;
  logic [15:0]       clip_cnt;
`endif

  modport master (
    output gain_mv, gain_load, din_valid, din,
`ifdef AMP_SCALER_CLIP_CNT_EN
    output clip_clr,
    input  clip_cnt,
`endif
    input  dout_valid, dout, clip, busy, pending
  );

  modport slave (
    input  gain_mv, gain_load, din_valid, din,
`ifdef AMP_SCALER_CLIP_CNT_EN
    input  clip_clr,
    output clip_cnt,
`endif
    output dout_valid, dout, clip, busy, pending
  );
endinterface

// File: rtl/amp_scaler_pipe.sv
// Pipelined offset-binary amplitude scaler with mV->Q1.15 gain divider and zero-crossing gain update.
// Optional saturating clip counter: define AMP_SCALER_CLIP_CNT_EN.
module amp_scaler_pipe #(
  parameter int DATA_W        = 14,
  parameter int GAIN_W        = 12,
  parameter int FULL_SCALE_MV = 3080,
  parameter int RESET_MV      = 3080,
  parameter int COEF_W        = 16,
  parameter int APPLY_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  amp_scaler_pipe_if.slave bus_io
);
  localparam int FRAC   = 15;
  localparam int DIV_W  = GAIN_W + FRAC;
  localparam int RQ_W   = (FULL_SCALE_MV > 1) ? $clog2(FULL_SCALE_MV) : 1;
  localparam int CNT_W  = $clog2(DIV_W + 1);
  localparam int WT_W   = $clog2(APPLY_TIMEOUT + 1);
  localparam int D_W    = DATA_W + 1;
  localparam int PROD_W = D_W + COEF_W + 1;

  localparam logic [DATA_W-1:0]   MID      = DATA_W'(((2 ** DATA_W) - 1) / 2);
  localparam logic [DATA_W-1:0]   DMAX     = '1;
  localparam logic [COEF_W-1:0]   COEF_MAX = '1;
  localparam logic [63:0]         RESET_RAW  = (64'(RESET_MV) << FRAC) / 64'(FULL_SCALE_MV);
  localparam logic [COEF_W-1:0]   RESET_COEF = (RESET_RAW > 64'(COEF_MAX)) ? COEF_MAX : RESET_RAW[COEF_W-1:0];
  localparam logic [RQ_W:0]       DIVISOR  = (RQ_W + 1)'(FULL_SCALE_MV);
  localparam logic signed [PROD_W:0] RND      = (PROD_W + 1)'(2 ** (FRAC - 1));
  localparam logic signed [PROD_W:0] MID_EXT  = (PROD_W + 1)'(MID);
  localparam logic signed [PROD_W:0] DMAX_EXT = (PROD_W + 1)'(DMAX);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  dvd_q, dvd_d, quo_q, quo_d;
  logic [RQ_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WT_W-1:0]   wait_q, wait_d;
  logic              queued_q, queued_d;
  logic [GAIN_W-1:0] queued_mv_q, queued_mv_d;
  logic [COEF_W-1:0] active_coef_q, active_coef_d;
  logic              prev_neg_q, have_prev_q;

  logic [RQ_W:0]     rem_shift;
  logic              rem_ge, start_div, apply, din_neg, crossing;
  logic [GAIN_W-1:0] start_mv;
  logic [COEF_W-1:0] pend_coef;

  assign rem_shift = {rem_q, dvd_q[DIV_W-1]};
  assign rem_ge    = (rem_shift >= DIVISOR);
  assign pend_coef = (|quo_q[DIV_W-1:COEF_W]) ? COEF_MAX : quo_q[COEF_W-1:0];
  assign din_neg   = (bus_io.din < MID);
  assign crossing  = bus_io.din_valid && have_prev_q && (din_neg != prev_neg_q);

  always_comb begin
    state_d       = state_q;
    dvd_d         = dvd_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    cnt_d         = cnt_q;
    wait_d        = wait_q;
    queued_d      = queued_q;
    queued_mv_d   = queued_mv_q;
    active_coef_d = active_coef_q;
    apply         = 1'b0;
    start_div     = 1'b0;
    start_mv      = bus_io.gain_mv;
    case (state_q)
      ST_IDLE: start_div = bus_io.gain_load;
      ST_DIV: begin
        dvd_d = dvd_q << 1;
        rem_d = rem_ge ? RQ_W'(rem_shift - DIVISOR) : rem_shift[RQ_W-1:0];
        quo_d = {quo_q[DIV_W-2:0], rem_ge};
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_io.gain_load) begin
          queued_d    = 1'b1;
          queued_mv_d = bus_io.gain_mv;
        end
        // A load queued during the divide supersedes this result outright.
        if (cnt_q == CNT_W'(DIV_W - 1)) begin
          if (bus_io.gain_load || queued_q) begin
            start_div = 1'b1;
            start_mv  = bus_io.gain_load ? bus_io.gain_mv : queued_mv_q;
          end else begin
            state_d = ST_WAIT;
            wait_d  = '0;
          end
        end
      end
      ST_WAIT: begin
        wait_d = wait_q + WT_W'(1);
        if (bus_io.gain_load) begin
          start_div = 1'b1;
        end else if (crossing || (wait_q == WT_W'(APPLY_TIMEOUT - 1))) begin
          apply         = 1'b1;
          active_coef_d = pend_coef;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_div) begin
      state_d  = ST_DIV;
      dvd_d    = {start_mv, {FRAC{1'b0}}};
      rem_d    = '0;
      quo_d    = '0;
      cnt_d    = '0;
      queued_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      dvd_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      cnt_q         <= '0;
      wait_q        <= '0;
      queued_q      <= 1'b0;
      queued_mv_q   <= '0;
      active_coef_q <= RESET_COEF;
      prev_neg_q    <= 1'b0;
      have_prev_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      dvd_q         <= dvd_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      cnt_q         <= cnt_d;
      wait_q        <= wait_d;
      queued_q      <= queued_d;
      queued_mv_q   <= queued_mv_d;
      active_coef_q <= active_coef_d;
      if (bus_io.din_valid) begin
        prev_neg_q  <= din_neg;
        have_prev_q <= 1'b1;
      end
    end
  end

  logic                     v1_q, v2_q, v3_q, clip_q;
  logic signed [D_W-1:0]    d1_q;
  logic [COEF_W-1:0]        coef1_q;
  logic signed [PROD_W-1:0] p2_q;
  logic [DATA_W-1:0]        dout_q;
  logic signed [PROD_W:0]   p_rnd, r_shr, y_full;
  logic [DATA_W-1:0]        y_sat;
  logic                     y_clip;

  always_comb begin
    p_rnd  = (PROD_W + 1)'(p2_q) + RND;
    r_shr  = p_rnd >>> FRAC;
    y_full = r_shr + MID_EXT;
    y_clip = 1'b1;
    if (y_full < 0)             y_sat = '0;
    else if (y_full > DMAX_EXT) y_sat = DMAX;
    else begin
      y_sat  = y_full[DATA_W-1:0];
      y_clip = 1'b0;
    end
  end

  // The sample that triggers the update already sees the new coefficient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      d1_q    <= '0;
      coef1_q <= '0;
      p2_q    <= '0;
      dout_q  <= MID;
      clip_q  <= 1'b0;
    end else begin
      v1_q <= bus_io.din_valid;
      if (bus_io.din_valid) begin
        d1_q    <= $signed({1'b0, bus_io.din}) - $signed({1'b0, MID});
        coef1_q <= apply ? pend_coef : active_coef_q;
      end
      v2_q <= v1_q;
      if (v1_q) p2_q <= PROD_W'(d1_q) * PROD_W'($signed({1'b0, coef1_q}));
      v3_q <= v2_q;
      if (v2_q) dout_q <= y_sat;
      clip_q <= v2_q & y_clip;
    end
  end

  assign bus_io.dout_valid = v3_q;
  assign bus_io.dout       = dout_q;
  assign bus_io.clip       = clip_q;
  assign bus_io.busy       = (state_q == ST_DIV);
  assign bus_io.pending    = (state_q == ST_WAIT);

`ifdef AMP_SCALER_CLIP_CNT_EN
  logic [15:0] clip_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     clip_cnt_q <= '0;
    else if (bus_io.clip_clr)                       clip_cnt_q <= '0;
    else if (v2_q && y_clip && (clip_cnt_q != '1))  clip_cnt_q <= clip_cnt_q + 16'd1;
  end
  assign bus_io.clip_cnt = clip_cnt_q;
`endif
endmodule

// File: tb/tb_amp_scaler_pipe.sv
// Directed bench for amp_scaler_pipe: table-driven sample vectors plus hand sequences for
// divider latency, crossing/timeout update, load queueing and mid-divide reset.
module tb_amp_scaler_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  amp_scaler_pipe_if #(.DATA_W(14), .GAIN_W(12)) bus ();
  amp_scaler_pipe dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));

  typedef struct {
    int din;
    int exp_dout;
    int exp_clip;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t tbl_unity[5];
  vec_t tbl_hi[5];
  int stim_din[16];
  int stim_exp[16];
  int stim_n;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input int mv);
    bus.gain_mv   = 12'(mv);
    bus.gain_load = 1'b1;
    tick();
    bus.gain_load = 1'b0;
  endtask

  task automatic wait_busy(output int cnt, output bit pend_seen);
    cnt = 0;
    pend_seen = 1'b0;
    while (bus.busy && cnt < 200) begin
      cnt++;
      if (bus.pending) pend_seen = 1'b1;
      tick();
    end
  endtask

  task automatic send_one(input string name, input int din, input int exp_dout, input int exp_clip);
    bus.din = 14'(din);
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    tick();
    tick();
    check({name, " valid"}, int'(bus.dout_valid), 1);
    check({name, " dout"}, int'(bus.dout), exp_dout);
    check({name, " clip"}, int'(bus.clip), exp_clip);
    $display("[TB] %s din=%0d dout=%0d clip=%0d", name, din, bus.dout, bus.clip);
  endtask

  task automatic run_stream(input string name);
    for (int i = 0; i < stim_n + 3; i++) begin
      if (i >= 3) begin
        check($sformatf("%s[%0d] valid", name, i - 3), int'(bus.dout_valid), 1);
        check($sformatf("%s[%0d] dout", name, i - 3), int'(bus.dout), stim_exp[i - 3]);
      end
      if (i < stim_n) begin
        bus.din = 14'(stim_din[i]);
        bus.din_valid = 1'b1;
      end else begin
        bus.din_valid = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, b, pc;
    bit ps;

    tbl_unity[0] = '{0, 0, 0};
    tbl_unity[1] = '{16383, 16383, 0};
    tbl_unity[2] = '{8191, 8191, 0};
    tbl_unity[3] = '{1, 1, 0};
    tbl_unity[4] = '{12000, 12000, 0};
    tbl_hi[0] = '{4191, 2873, 0};      // crossing: first sample on coef 43566
    tbl_hi[1] = '{16383, 16383, 1};
    tbl_hi[2] = '{0, 0, 1};
    tbl_hi[3] = '{8191, 8191, 0};
    tbl_hi[4] = '{12191, 13509, 0};

    bus.gain_mv = '0;
    bus.gain_load = 1'b0;
    bus.din_valid = 1'b0;
    bus.din = '0;
`ifdef AMP_SCALER_CLIP_CNT_EN
    bus.clip_clr = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset dout", int'(bus.dout), 8191);
    check("reset dout_valid", int'(bus.dout_valid), 0);
    check("reset clip", int'(bus.clip), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset pending", int'(bus.pending), 0);
    rst_n = 1'b1;
    tick();

    // Exact 3-cycle latency with unity coefficient
    bus.din = 14'd12000;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("lat valid@%0d", i), int'(bus.dout_valid), (i == 3) ? 1 : 0);
      if (i == 3) begin
        check("lat dout", int'(bus.dout), 12000);
        check("lat clip", int'(bus.clip), 0);
        $display("[TB] latency din=12000 dout=%0d", bus.dout);
      end
      tick();
    end

    for (int i = 0; i < 5; i++)
      send_one($sformatf("unity%0d", i), tbl_unity[i].din, tbl_unity[i].exp_dout, tbl_unity[i].exp_clip);

    // 1540 mV -> coef 16384, applied on first crossing of square wave
    load(1540);
    wait_busy(cnt, ps);
    check("1540 busy cycles", cnt, 27);
    check("1540 pending", int'(bus.pending), 1);
    stim_n = 8;
    for (int i = 0; i < 8; i++) begin
      stim_din[i] = (i < 3 || i >= 6) ? 12191 : 4191;
      stim_exp[i] = (i < 3) ? 12191 : ((i < 6) ? 6191 : 10191);
    end
    run_stream("square");
    check("square pending after", int'(bus.pending), 0);

    // 4095 mV -> coef 43566, saturation
    load(4095);
    wait_busy(cnt, ps);
    check("4095 busy cycles", cnt, 27);
    check("4095 pending", int'(bus.pending), 1);
    for (int i = 0; i < 5; i++)
      send_one($sformatf("hi%0d", i), tbl_hi[i].din, tbl_hi[i].exp_dout, tbl_hi[i].exp_clip);
    check("4095 pending after", int'(bus.pending), 0);

`ifdef AMP_SCALER_CLIP_CNT_EN
    bus.clip_clr = 1'b1;
    tick();
    bus.clip_clr = 1'b0;
    check("clip_cnt cleared", int'(bus.clip_cnt), 0);
    for (int i = 0; i < 5; i++)
      send_one($sformatf("cc%0d", i), (i < 3) ? 16383 : 0, (i < 3) ? 16383 : 0, 1);
    check("clip_cnt five", int'(bus.clip_cnt), 5);
    bus.clip_clr = 1'b1;
    tick();
    bus.clip_clr = 1'b0;
    check("clip_cnt clr", int'(bus.clip_cnt), 0);
    send_one("cc_last", 12191, 13509, 0);
`endif

    // Loads 1000 then 2000 three cycles apart: divides run back to back, only 2000 applies
    load(1000);
    b = 0;
    ps = 1'b0;
    repeat (2) begin
      if (bus.busy) b++;
      if (bus.pending) ps = 1'b1;
      tick();
    end
    if (bus.busy) b++;
    if (bus.pending) ps = 1'b1;
    load(2000);
    wait_busy(cnt, pc[0]);
    if (pc[0]) ps = 1'b1;
    check("queued busy cycles", b + cnt, 54);
    check("queued no early pending", int'(ps), 0);
    check("queued pending", int'(bus.pending), 1);
    send_one("q_neg", 4191, 5594, 0);
    send_one("q_pos", 12191, 10788, 0);

    // Timeout apply with DC input (no crossing)
    load(1540);
    wait_busy(cnt, ps);
    check("timeout busy cycles", cnt, 27);
    bus.din = 14'd9000;
    bus.din_valid = 1'b1;
    pc = 0;
    while (bus.pending && pc < 1100) begin
      pc++;
      tick();
    end
    check("timeout pending cycles", pc, 1024);
    tick();
    check("timeout old coef dout", int'(bus.dout), 8716);
    tick();
    check("timeout new coef dout", int'(bus.dout), 8596);
    $display("[TB] timeout pending_cycles=%0d dout=%0d", pc, bus.dout);
    bus.din_valid = 1'b0;
    repeat (4) tick();

    // Asynchronous reset during divide
    load(2000);
    repeat (10) tick();
    check("pre-reset busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("async reset busy", int'(bus.busy), 0);
    check("async reset pending", int'(bus.pending), 0);
    check("async reset dout", int'(bus.dout), 8191);
    check("async reset dout_valid", int'(bus.dout_valid), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send_one("post_reset", 12000, 12000, 0);
    b = 0;
    repeat (40) begin
      if (bus.busy || bus.pending) b++;
      tick();
    end
    check("post_reset idle", b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
